// File: rtl/prog_loader_if.sv
// Byte-stream input and program-memory write port of the program loader.
// The loader (slave) receives bytes and drives memory/CPU control; the source/observer is master.
interface prog_loader_if;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_ready;
   logic        mem_we;
   logic [12:0] mem_addr;
   logic [13:0] mem_wdata;
   logic        cpu_hold;
   logic        done;
   logic        err;

   modport master (
      output rx_data, rx_valid,
      input  rx_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, err
   );

   modport slave (
      input  rx_data, rx_valid,
      output rx_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, err
   );
endinterface

// File: rtl/prog_loader.sv
// Serial program loader: parses sync/count/data/checksum byte stream into 14-bit memory writes,
// holding the CPU in reset while a load is in progress.
module prog_loader #(
   parameter int unsigned MAX_WORDS = 8191
) (
   input logic         clk,
   input logic         reset,
   prog_loader_if.slave bus
);

   typedef enum logic [2:0] {
      StIdle, StCntH, StCntL, StDataH, StDataL, StCheck, StDone, StErr
   } state_e;

   state_e      state_q;
   logic [12:0] count_q;
   logic [12:0] idx_q;
   logic [5:0]  hi_q;
   logic [7:0]  sum_q;
   logic        mem_we_q;
   logic [12:0] mem_addr_q;
   logic [13:0] mem_wdata_q;

   logic        rx_ready;
   logic        accept;
   logic [12:0] cnt_full;

   assign rx_ready = (state_q != StDone) && (state_q != StErr);
   assign accept   = bus.rx_valid && rx_ready;
   assign cnt_full = {count_q[12:8], bus.rx_data};

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= StIdle;
         count_q     <= '0;
         idx_q       <= '0;
         hi_q        <= '0;
         sum_q       <= '0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         mem_we_q <= 1'b0;
         case (state_q)
            StIdle: begin
               if (accept && bus.rx_data == 8'hA5) begin
                  state_q <= StCntH;
                  sum_q   <= '0;
                  idx_q   <= '0;
               end
            end
            StCntH: begin
               if (accept) begin
                  sum_q   <= sum_q + bus.rx_data;
                  count_q <= {bus.rx_data[4:0], 8'h00};
                  state_q <= (bus.rx_data[7:5] != 3'b000) ? StErr : StCntL;
               end
            end
            StCntL: begin
               if (accept) begin
                  sum_q   <= sum_q + bus.rx_data;
                  count_q <= cnt_full;
                  idx_q   <= '0;
                  if (32'(cnt_full) > MAX_WORDS) begin
                     state_q <= StErr;
                  end else if (cnt_full == 13'd0) begin
                     state_q <= StCheck;
                  end else begin
                     state_q <= StDataH;
                  end
               end
            end
            StDataH: begin
               if (accept) begin
                  sum_q   <= sum_q + bus.rx_data;
                  hi_q    <= bus.rx_data[5:0];
                  state_q <= (bus.rx_data[7:6] != 2'b00) ? StErr : StDataL;
               end
            end
            StDataL: begin
               if (accept) begin
                  sum_q       <= sum_q + bus.rx_data;
                  mem_we_q    <= 1'b1;
                  mem_addr_q  <= idx_q;
                  mem_wdata_q <= {hi_q, bus.rx_data};
                  idx_q       <= idx_q + 13'd1;
                  // idx_q still holds the pre-increment index of this word
                  state_q     <= (idx_q == count_q - 13'd1) ? StCheck : StDataH;
               end
            end
            StCheck: begin
               if (accept) begin
                  state_q <= (bus.rx_data == sum_q) ? StDone : StErr;
               end
            end
            StDone:  state_q <= StIdle;
            StErr:   state_q <= StIdle;
            default: state_q <= StIdle;
         endcase
      end
   end

   assign bus.rx_ready  = rx_ready;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign bus.cpu_hold  = (state_q != StIdle);
   assign bus.done      = (state_q == StDone);
   assign bus.err       = (state_q == StErr);

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: a behavioural stream parser predicts writes and done/err
// pulses as bytes are driven; a negedge monitor pops and compares them as the DUT emits them.
module tb_prog_loader;

   localparam int EvWrite = 0;
   localparam int EvDone  = 1;
   localparam int EvErr   = 2;

   typedef struct {
      int          kind;
      logic [12:0] addr;
      logic [13:0] data;
   } ev_t;

   logic clk = 1'b0;
   logic reset;
   prog_loader_if bus ();

   prog_loader #(.MAX_WORDS(8191)) u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int   n_checks = 0;
   int   n_fail   = 0;
   int   n_writes = 0;
   ev_t  sb[$];

   // reference parser state
   int          m_st = 0;
   logic [12:0] m_cnt, m_idx;
   logic [5:0]  m_hi;
   logic [7:0]  m_sum;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic push_ev(input int kind, input logic [12:0] a, input logic [13:0] d);
      ev_t e;
      e.kind = kind;
      e.addr = a;
      e.data = d;
      sb.push_back(e);
   endtask

   task automatic model_byte(input logic [7:0] b);
      case (m_st)
         0: if (b == 8'hA5) begin m_st = 1; m_sum = 8'h00; m_idx = '0; end
         1: begin
            m_sum = m_sum + b;
            if (b[7:5] != 3'b000) begin push_ev(EvErr, '0, '0); m_st = 0; end
            else begin m_cnt = {b[4:0], 8'h00}; m_st = 2; end
         end
         2: begin
            m_sum = m_sum + b;
            m_cnt[7:0] = b;
            m_idx = '0;
            if (int'(m_cnt) > 8191) begin push_ev(EvErr, '0, '0); m_st = 0; end
            else m_st = (m_cnt == 13'd0) ? 5 : 3;
         end
         3: begin
            m_sum = m_sum + b;
            if (b[7:6] != 2'b00) begin push_ev(EvErr, '0, '0); m_st = 0; end
            else begin m_hi = b[5:0]; m_st = 4; end
         end
         4: begin
            m_sum = m_sum + b;
            push_ev(EvWrite, m_idx, {m_hi, b});
            m_idx = m_idx + 13'd1;
            m_st = (m_idx == m_cnt) ? 5 : 3;
         end
         default: begin
            push_ev((b == m_sum) ? EvDone : EvErr, '0, '0);
            m_st = 0;
         end
      endcase
   endtask

   task automatic pop_expect(input string tag, input int kind, input logic [12:0] a,
                             input logic [13:0] d);
      ev_t e;
      check_eq({tag, "_expected"}, 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
         e = sb.pop_front();
         check_eq({tag, "_kind"}, kind, e.kind);
         if (kind == EvWrite) begin
            check_eq({tag, "_addr"}, 32'(a), 32'(e.addr));
            check_eq({tag, "_data"}, 32'(d), 32'(e.data));
         end
      end
   endtask

   always @(negedge clk) begin
      if (reset === 1'b0) begin
         if (bus.mem_we === 1'b1) begin
            n_writes++;
            pop_expect("write", EvWrite, bus.mem_addr, bus.mem_wdata);
         end
         if (bus.done === 1'b1) begin
            check_eq("hold_at_done", 32'(bus.cpu_hold), 32'd1);
            pop_expect("done", EvDone, '0, '0);
         end
         if (bus.err === 1'b1) begin
            check_eq("hold_at_err", 32'(bus.cpu_hold), 32'd1);
            pop_expect("err", EvErr, '0, '0);
         end
      end
   end

   // Called at a negedge; returns at the negedge right after the byte was accepted.
   task automatic send_byte(input logic [7:0] b, input int gap);
      int n = 0;
      repeat (gap) @(negedge clk);
      model_byte(b);
      bus.rx_data  = b;
      bus.rx_valid = 1'b1;
      while (bus.rx_ready !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (n >= 20) check_eq("rx_ready_timeout", 32'(n), 32'd0);
      @(negedge clk);
      bus.rx_valid = 1'b0;
   endtask

   task automatic send_seq(input logic [7:0] bytes[$], input int max_gap);
      foreach (bytes[i]) send_byte(bytes[i], $urandom_range(0, max_gap));
   endtask

   task automatic drain(input string tag);
      int n = 0;
      while (sb.size() != 0 && n < 30) begin
         @(negedge clk);
         n++;
      end
      repeat (3) @(negedge clk);
      check_eq({tag, "_drain"}, sb.size(), 32'd0);
      check_eq({tag, "_idle_hold"}, 32'(bus.cpu_hold), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int w0;
      logic [7:0] q[$];
      logic [7:0] sum;
      logic [7:0] b;

      reset = 1'b1;
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'h00;
      repeat (3) @(negedge clk);
      check_eq("rst_we",    32'(bus.mem_we),    32'd0);
      check_eq("rst_addr",  32'(bus.mem_addr),  32'd0);
      check_eq("rst_wdata", 32'(bus.mem_wdata), 32'd0);
      check_eq("rst_hold",  32'(bus.cpu_hold),  32'd0);
      check_eq("rst_done",  32'(bus.done),      32'd0);
      check_eq("rst_err",   32'(bus.err),       32'd0);
      reset = 1'b0;
      @(negedge clk);
      check_eq("rst_ready", 32'(bus.rx_ready),  32'd1);

      // leading junk ignored, empty program loads
      w0 = n_writes;
      send_byte(8'h00, 0);
      send_byte(8'h11, 1);
      check_eq("junk_hold", 32'(bus.cpu_hold), 32'd0);
      send_byte(8'hA5, 0);
      check_eq("sync_hold", 32'(bus.cpu_hold), 32'd1);
      q = '{8'h00, 8'h00, 8'h00};
      send_seq(q, 0);
      drain("empty");
      check_eq("empty_writes", n_writes - w0, 32'd0);

      // two-word load, back to back
      w0 = n_writes;
      q = '{8'hA5, 8'h00, 8'h02, 8'h3F, 8'hFF, 8'h00, 8'h12, 8'h52};
      send_seq(q, 0);
      drain("good");
      check_eq("good_writes", n_writes - w0, 32'd2);
      check_eq("hold_addr",  32'(bus.mem_addr),  32'h001);
      check_eq("hold_wdata", 32'(bus.mem_wdata), 32'h0012);

      // same load, bad checksum, with gaps
      w0 = n_writes;
      q = '{8'hA5, 8'h00, 8'h02, 8'h3F, 8'hFF, 8'h00, 8'h12, 8'h53};
      send_seq(q, 3);
      drain("badchk");
      check_eq("badchk_writes", n_writes - w0, 32'd2);

      // DATA_H with high bits set
      w0 = n_writes;
      q = '{8'hA5, 8'h00, 8'h01, 8'h40};
      send_seq(q, 0);
      drain("badhi");
      check_eq("badhi_writes", n_writes - w0, 32'd0);
      check_eq("badhi_ready", 32'(bus.rx_ready), 32'd1);

      // CNT_H with high bits set
      q = '{8'hA5, 8'h20};
      send_seq(q, 1);
      drain("badcnt");

      // 0xA5 inside the stream is data
      q = '{8'hA5, 8'h00, 8'h01, 8'h00, 8'hA5, 8'hA6};
      send_seq(q, 0);
      drain("a5data");

      // random six-word load with random gaps
      q = '{8'hA5, 8'h00, 8'h06};
      sum = 8'h06;
      for (int i = 0; i < 12; i++) begin
         b = 8'($urandom_range(0, 255));
         if (i % 2 == 0) b[7:6] = 2'b00;
         q.push_back(b);
         sum = sum + b;
      end
      q.push_back(sum);
      w0 = n_writes;
      send_seq(q, 3);
      drain("rand");
      check_eq("rand_writes", n_writes - w0, 32'd6);

      // reset one cycle after the first write, valid toggling
      w0 = n_writes;
      q = '{8'hA5, 8'h00, 8'h02, 8'h3F, 8'hFF};
      foreach (q[i]) send_byte(q[i], 1);
      check_eq("rst_first_we", 32'(bus.mem_we), 32'd1);
      @(negedge clk);
      reset = 1'b1;
      bus.rx_data  = 8'h00;
      bus.rx_valid = 1'b1;
      m_st = 0;
      @(negedge clk);
      bus.rx_valid = 1'b0;
      check_eq("rst_mid_hold", 32'(bus.cpu_hold), 32'd0);
      check_eq("rst_mid_we",   32'(bus.mem_we),   32'd0);
      @(negedge clk);
      bus.rx_valid = 1'b1;
      reset = 1'b0;
      @(negedge clk);
      bus.rx_valid = 1'b0;
      check_eq("rst_after_hold", 32'(bus.cpu_hold), 32'd0);
      q = '{8'h12, 8'h52};
      foreach (q[i]) send_byte(q[i], 1);
      drain("rstmid");
      check_eq("rstmid_writes", n_writes - w0, 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter: MAX_WORDS, 8191, largest accepted word count (program memory depth minus one).
REQ-002 clk  in  1  clock; all logic on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 rx_data  in  8  incoming byte of the load stream.
REQ-005 rx_valid  in  1  rx_data holds a byte.
REQ-006 rx_ready  out  1  loader can accept a byte; a byte transfers when rx_valid && rx_ready.
REQ-007 mem_we  out  1  one-cycle write strobe to the 14-bit program memory.
REQ-008 mem_addr  out  13  program memory word address.
REQ-009 mem_wdata  out  14  instruction word to write.
REQ-010 cpu_hold  out  1  holds the CPU program counter in reset while a load is in progress.
REQ-011 done  out  1  one-cycle pulse: load completed with good checksum.
REQ-012 err  out  1  one-cycle pulse: load aborted on a format or checksum error.

Function
REQ-013 Stream format SHALL be: sync 0xA5, CNT_H, CNT_L, then count x (DATA_H, DATA_L), then CHK.
REQ-014 FSM states SHALL be IDLE, CNT_H, CNT_L, DATA_H, DATA_L, CHECK, DONE, ERR; transitions occur only on an accepted byte, except DONE and ERR.
REQ-015 rx_ready SHALL be 1 in IDLE..CHECK and 0 in DONE and ERR.
REQ-016 IDLE: accepted 0xA5 -> CNT_H; any other byte is discarded and the FSM stays in IDLE.
REQ-017 CNT_H: count[12:8] = byte[4:0]; byte[7:5] != 0 -> ERR.
REQ-018 CNT_L: count[7:0] = byte; count > MAX_WORDS -> ERR; count == 0 -> CHECK; else -> DATA_H with word index = 0.
REQ-019 DATA_H: latch byte[5:0] as hi; byte[7:6] != 0 -> ERR, else -> DATA_L.
REQ-020 DATA_L: on acceptance, the next cycle SHALL drive mem_we=1 for exactly one cycle, with mem_addr = word index and mem_wdata = {hi, byte}.
REQ-021 The word index SHALL increment after each write; after the count-th write -> CHECK, else -> DATA_H.
REQ-022 The checksum SHALL be the 8-bit modulo-256 sum of CNT_H, CNT_L and all DATA bytes; the sync and CHK bytes are excluded.
REQ-023 CHECK: byte == checksum -> DONE, else -> ERR; writes already issued are not undone.
REQ-024 DONE and ERR SHALL last one cycle each, asserting done or err respectively, then return to IDLE.
REQ-025 cpu_hold SHALL be 1 whenever state != IDLE: it rises the cycle after sync acceptance and falls the cycle after DONE or ERR.
REQ-026 Gaps in rx_valid of any length SHALL NOT change the result; there is no timeout.
REQ-027 mem_addr and mem_wdata SHALL hold their last values when mem_we=0.
REQ-028 A second 0xA5 received after sync SHALL be treated as data, not as a resync.

Reset
REQ-029 While reset is high, the FSM SHALL go to IDLE, and the count, index, hi and checksum registers SHALL clear to 0.
REQ-030 While reset is high, mem_we, mem_addr, mem_wdata, cpu_hold, done and err SHALL be 0, and rx_ready SHALL be 1 from the first cycle after reset.
REQ-031 Reset mid-load SHALL abort with no further mem_we and no done/err pulse, and a pending DATA_L write SHALL be cancelled.

Verification
REQ-032 Reset -> all outputs 0 except rx_ready=1 from the cycle after reset deasserts.
REQ-033 Stream A5 00 02 3F FF 00 12 52 -> writes (0x000, 0x3FFF) then (0x001, 0x0012), one done pulse, err=0, cpu_hold high from after A5 through DONE.
REQ-034 Same stream with CHK=0x53 -> both writes occur, then one err pulse and no done.
REQ-035 Bytes 00 11 then A5 00 00 00 -> leading bytes ignored with cpu_hold=0 during them; no writes; done pulse.
REQ-036 A5 00 01 40 -> err pulse after the 0x40 byte, no mem_we, FSM back in IDLE.
REQ-037 Stream of REQ-033 with reset asserted one cycle after the first write, and rx_valid toggled every other cycle -> exactly one write, no done/err, cpu_hold=0 the cycle after reset.
